// File: rtl/element_pkg.sv
// Shared types for the element-wise matrix ALU.
//   op_e    : operation encoding (5..7 are illegal and rejected in CHECK)
//   state_e : engine FSM states
//   dim_t   : shape field for the default WIDTH_BIT (1..WIDTH in WIDTH_BIT+1 bits)
package element_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int WIDTH_BIT_DEF = 2;

    typedef logic [WIDTH_BIT_DEF:0] dim_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        RUN      = 3'd2,
        DIV_WAIT = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/element_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// The first iteration is folded into the start edge, so done pulses exactly
// DATA_W-1 cycles after start and results are stable while done is high.
// Divisor 0 falls out of the algorithm as quotient all ones, remainder =
// dividend; div_zero flags it.
// Ports:
//   clk, rst            clock, synchronous active-high reset (aborts a divide)
//   start               load dividend/divisor and begin
//   dividend, divisor   operands, sampled on start
//   busy                iterations in progress
//   done                one-cycle pulse, quotient/remainder valid
//   div_zero            divisor of the current/last divide was 0
//   quotient, remainder results
module element_divider
    import element_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0]  cnt_q;

    // one restoring step on either the fresh operands or the running state
    logic [DATA_W-1:0] s_rem, s_quo, s_dvs, n_rem, n_quo;
    logic [DATA_W:0]   partial;
    logic [DATA_W+1:0] trial;

    always_comb begin
        s_rem   = start ? '0 : rem_q;
        s_quo   = start ? dividend : quo_q;
        s_dvs   = start ? divisor : dvs_q;
        partial = {s_rem, s_quo[DATA_W-1]};
        trial   = {1'b0, partial} - {2'b00, s_dvs};
        // no borrow -> subtraction fits, quotient bit 1
        if (!trial[DATA_W+1]) begin
            n_rem = trial[DATA_W-1:0];
            n_quo = {s_quo[DATA_W-2:0], 1'b1};
        end else begin
            n_rem = partial[DATA_W-1:0];
            n_quo = {s_quo[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q    <= n_rem;
                quo_q    <= n_quo;
                dvs_q    <= divisor;
                div_zero <= (divisor == '0);
                cnt_q    <= CNT_W'(DATA_W - 1);
                busy     <= 1'b1;
            end else if (busy) begin
                rem_q <= n_rem;
                quo_q <= n_quo;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/element_op_engine.sv
// Sequential element-wise matrix ALU (add/sub/mul/div/mod), one element per
// step in row-major order over the active rows x cols region.
// Optional macro ELEMENT_OP_SAT_EN: ADD/MUL clamp to all ones on overflow,
// SUB clamps to 0 on underflow; default build wraps modulo 2**DATA_W.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 launch op, sampled only in IDLE
//   op                    0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD
//   rows_a/cols_a/rows_b/cols_b  active shapes (1..WIDTH)
//   a, b                  operand matrices (captured at start)
//   busy                  high in every state but IDLE
//   done                  one-cycle completion pulse
//   valid_op              shape/op check result, valid with done
//   div_zero              sticky: some div/mod element had divisor 0
//   result                result matrix, held until next accepted start
module element_op_engine
    import element_pkg::*;
#(
    parameter int WIDTH_BIT = WIDTH_BIT_DEF,
    parameter int WIDTH     = 2 ** WIDTH_BIT,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [2:0]                               op,
    input  logic [WIDTH_BIT:0]                       rows_a,
    input  logic [WIDTH_BIT:0]                       cols_a,
    input  logic [WIDTH_BIT:0]                       rows_b,
    input  logic [WIDTH_BIT:0]                       cols_b,
    input  logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0]  a,
    input  logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0]  b,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     valid_op,
    output logic                                     div_zero,
    output logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0]  result
);

`ifdef ELEMENT_OP_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [WIDTH_BIT:0] DIM_MAX = (WIDTH_BIT+1)'(WIDTH);

    state_e                                   state_q;
    logic [2:0]                               op_q;
    logic [WIDTH_BIT:0]                       rows_a_q, cols_a_q, rows_b_q, cols_b_q;
    logic [0:WIDTH-1][0:WIDTH-1][DATA_W-1:0]  a_q, b_q;
    logic [WIDTH_BIT-1:0]                     row_q, col_q;

    // ---------------- element datapath ----------------
    logic [DATA_W-1:0]   elem_a, elem_b, alu_res;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;
    logic                is_div;

    always_comb begin
        elem_a  = a_q[row_q][col_q];
        elem_b  = b_q[row_q][col_q];
        sum     = {1'b0, elem_a} + {1'b0, elem_b};
        prod    = {{DATA_W{1'b0}}, elem_a} * {{DATA_W{1'b0}}, elem_b};
        is_div  = (op_q == OP_DIV) || (op_q == OP_MOD);
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = (SAT_EN && sum[DATA_W]) ? '1 : sum[DATA_W-1:0];
            OP_SUB:  alu_res = (SAT_EN && (elem_a < elem_b)) ? '0 : elem_a - elem_b;
            OP_MUL:  alu_res = (SAT_EN && (prod[2*DATA_W-1:DATA_W] != '0)) ? '1
                                                                           : prod[DATA_W-1:0];
            default: alu_res = '0;
        endcase
    end

    // ---------------- shape check and index walk ----------------
    logic shape_ok, col_last, last_elem;
    logic [WIDTH_BIT-1:0] nxt_row, nxt_col;

    always_comb begin
        shape_ok  = (rows_a_q == rows_b_q) && (cols_a_q == cols_b_q) &&
                    (rows_a_q != '0) && (rows_a_q <= DIM_MAX) &&
                    (cols_a_q != '0) && (cols_a_q <= DIM_MAX) &&
                    (op_q <= 3'(OP_MOD));
        col_last  = ({1'b0, col_q} == cols_a_q - 1'b1);
        last_elem = col_last && ({1'b0, row_q} == rows_a_q - 1'b1);
        nxt_col   = col_last ? '0 : col_q + 1'b1;
        nxt_row   = col_last ? row_q + 1'b1 : row_q;
    end

    // ---------------- shared divider ----------------
    logic              div_start, div_busy, div_done, div_dz;
    logic [DATA_W-1:0] div_quo, div_rem;

    // launched combinationally from RUN so the divider starts on the issue edge
    assign div_start = (state_q == RUN) && is_div && !div_busy;

    element_divider #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (elem_a),
        .divisor   (elem_b),
        .busy      (div_busy),
        .done      (div_done),
        .div_zero  (div_dz),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid_op <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
            op_q     <= '0;
            rows_a_q <= '0;
            cols_a_q <= '0;
            rows_b_q <= '0;
            cols_b_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        rows_a_q <= rows_a;
                        cols_a_q <= cols_a;
                        rows_b_q <= rows_b;
                        cols_b_q <= cols_b;
                        a_q      <= a;
                        b_q      <= b;
                        result   <= '0;
                        div_zero <= 1'b0;
                        valid_op <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= CHECK;
                    end
                end
                CHECK: begin
                    row_q <= '0;
                    col_q <= '0;
                    if (shape_ok) begin
                        state_q <= RUN;
                    end else begin
                        state_q  <= DONE;
                        done     <= 1'b1;
                        valid_op <= 1'b0;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        state_q <= DIV_WAIT;
                    end else begin
                        result[row_q][col_q] <= alu_res;
                        if (last_elem) begin
                            state_q  <= DONE;
                            done     <= 1'b1;
                            valid_op <= 1'b1;
                        end else begin
                            row_q <= nxt_row;
                            col_q <= nxt_col;
                        end
                    end
                end
                DIV_WAIT: begin
                    if (div_done) begin
                        result[row_q][col_q] <= (op_q == OP_DIV) ? div_quo : div_rem;
                        if (div_dz) div_zero <= 1'b1;
                        if (last_elem) begin
                            state_q  <= DONE;
                            done     <= 1'b1;
                            valid_op <= 1'b1;
                        end else begin
                            row_q   <= nxt_row;
                            col_q   <= nxt_col;
                            state_q <= RUN;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_element_op_engine.sv
module tb_element_op_engine;
    import element_pkg::*;

`ifdef ELEMENT_OP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef logic [0:3][0:3][31:0] mat_t;

    typedef struct {
        string      name;
        logic [2:0] op;
        dim_t       ra, ca, rb, cb;
        mat_t       a, b;
        mat_t       er;
        logic       ev, edz;
        int         lat;
    } vec_t;

    typedef struct {
        string name;
        mat_t  er;
        logic  ev, edz;
        int    lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    dim_t       rows_a = '0, cols_a = '0, rows_b = '0, cols_b = '0;
    mat_t       a = '0, b = '0;
    logic       busy, done, valid_op, div_zero;
    mat_t       result;

    int   n_chk = 0, n_fail = 0, done_cnt = 0;
    exp_t sb[$];
    vec_t vt[$];

    element_op_engine dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rows_a(rows_a), .cols_a(cols_a), .rows_b(rows_b), .cols_b(cols_b),
        .a(a), .b(b), .busy(busy), .done(done), .valid_op(valid_op),
        .div_zero(div_zero), .result(result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] s;
        logic [63:0] p;
        s = {1'b0, x} + {1'b0, y};
        p = 64'(x) * 64'(y);
        case (o)
            3'd0:    return (SAT && s[32]) ? 32'hFFFF_FFFF : s[31:0];
            3'd1:    return (SAT && x < y) ? 32'h0 : x - y;
            3'd2:    return (SAT && p[63:32] != 0) ? 32'hFFFF_FFFF : p[31:0];
            3'd3:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic vec_t mkv(input string nm, input logic [2:0] o, input dim_t ra, input dim_t ca,
                                 input dim_t rb, input dim_t cb, input mat_t ma, input mat_t mb);
        vec_t v;
        v.name = nm; v.op = o; v.ra = ra; v.ca = ca; v.rb = rb; v.cb = cb; v.a = ma; v.b = mb;
        v.er = '0; v.edz = 1'b0; v.lat = 2;
        v.ev = (ra == rb) && (ca == cb) && ra >= 1 && ra <= 4 && ca >= 1 && ca <= 4 && o <= 4;
        if (v.ev) begin
            for (int i = 0; i < int'(ra); i++)
                for (int j = 0; j < int'(ca); j++) begin
                    v.er[i][j] = model(o, ma[i][j], mb[i][j]);
                    if (o >= 3 && mb[i][j] == 0) v.edz = 1'b1;
                end
            v.lat = 2 + int'(ra) * int'(ca) * ((o >= 3) ? 33 : 1);
        end
        return v;
    endfunction

    // Launch one op, watch for done with a cycle budget, then score it.
    // pulse_at > 0 puts an extra start pulse on edge T+pulse_at.
    task automatic run_vec(input vec_t v, input int pulse_at);
        exp_t e;
        int   lat;
        e.name = v.name; e.er = v.er; e.ev = v.ev; e.edz = v.edz; e.lat = v.lat;
        sb.push_back(e);
        @(negedge clk);
        op = v.op; rows_a = v.ra; cols_a = v.ca; rows_b = v.rb; cols_b = v.cb;
        a = v.a; b = v.b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = {16{32'hA5A5_5A5A}};
        b = {16{32'h0000_0003}};
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (k == pulse_at - 1) start = 1'b1;
            if (k == pulse_at) start = 1'b0;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({e.name, " latency"}, 512'(lat), 512'(e.lat));
        chk({e.name, " valid_op"}, 512'(valid_op), 512'(e.ev));
        chk({e.name, " div_zero"}, 512'(div_zero), 512'(e.edz));
        chk({e.name, " result"}, result, e.er);
        chk({e.name, " busy@done"}, 512'(busy), 512'(1));
        @(negedge clk);
        chk({e.name, " busy after"}, 512'(busy), 512'(0));
        chk({e.name, " done after"}, 512'(done), 512'(0));
    endtask

    initial begin
        mat_t ma, mb, er;
        vec_t v;
        int   dc;

        // ---- stimulus table ----
        ma = '0; mb = '0; er = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = 32'(i * 3 + j + 1);
                mb[i][j] = 32'd10;
                er[i][j] = 32'(11 + i * 3 + j);
            end
        v = mkv("add2x3", 3'd0, 2, 3, 2, 3, ma, mb); v.er = er; v.lat = 8; v.ev = 1'b1;
        vt.push_back(v);

        ma = '0; mb = '0; mb[0][0] = 32'd1; er = '0;
        er[0][0] = SAT ? 32'h0 : 32'hFFFF_FFFF;
        v = mkv("sub_under", 3'd1, 1, 1, 1, 1, ma, mb); v.er = er; v.lat = 3;
        vt.push_back(v);

        ma = '0; mb = '0; ma[0][0] = 32'h1_0000; mb[0][0] = 32'h1_0000; er = '0;
        er[0][0] = SAT ? 32'hFFFF_FFFF : 32'h0;
        v = mkv("mul_ovf", 3'd2, 1, 1, 1, 1, ma, mb); v.er = er; v.lat = 3;
        vt.push_back(v);

        ma = '0; mb = '0; ma[0][0] = 7; ma[0][1] = 9; mb[0][0] = 2; mb[0][1] = 0;
        er = '0; er[0][0] = 3; er[0][1] = 32'hFFFF_FFFF;
        v = mkv("div1x2", 3'd3, 1, 2, 1, 2, ma, mb); v.er = er; v.edz = 1'b1; v.lat = 68;
        vt.push_back(v);
        er = '0; er[0][0] = 1; er[0][1] = 9;
        v = mkv("mod1x2", 3'd4, 1, 2, 1, 2, ma, mb); v.er = er; v.edz = 1'b1; v.lat = 68;
        vt.push_back(v);

        ma = {16{32'h1234_5678}};
        v = mkv("shape_mis", 3'd0, 2, 2, 3, 2, ma, ma); v.er = '0; v.ev = 1'b0; v.lat = 2;
        vt.push_back(v);
        v = mkv("op6", 3'd6, 2, 2, 2, 2, ma, ma); v.er = '0; v.ev = 1'b0; v.lat = 2;
        vt.push_back(v);
        v = mkv("rows0", 3'd0, 0, 2, 0, 2, ma, ma);
        vt.push_back(v);
        v = mkv("rows5", 3'd0, 5, 1, 5, 1, ma, ma);
        vt.push_back(v);

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 32'hFFFF_FFF0 + 32'(i * 4 + j);
                mb[i][j] = 32'h20 + 32'(j);
            end
        vt.push_back(mkv("add4x4_edge", 3'd0, 4, 4, 4, 4, ma, mb));
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = $urandom();
                mb[i][j] = $urandom_range(1, 32'h7FFF);
            end
        vt.push_back(mkv("mul3x3", 3'd2, 3, 3, 3, 3, ma, mb));
        vt.push_back(mkv("sub2x4", 3'd1, 2, 4, 2, 4, mb, ma));
        ma = '0; mb = '0; ma[0][0] = 100; mb[0][0] = 7;
        vt.push_back(mkv("div100_7", 3'd3, 1, 1, 1, 1, ma, mb));

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", 512'(busy), 512'(0));
        chk("reset done", 512'(done), 512'(0));
        chk("reset valid_op", 512'(valid_op), 512'(0));
        chk("reset div_zero", 512'(div_zero), 512'(0));
        chk("reset result", result, 512'(0));

        // ---- table ----
        foreach (vt[i]) run_vec(vt[i], 0);

        // ---- start while busy is ignored ----
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 32'(i * 16 + j);
                mb[i][j] = 32'(1000 * (i + 1));
            end
        dc = done_cnt;
        run_vec(mkv("busy_start", 3'd0, 4, 4, 4, 4, ma, mb), 3);
        repeat (25) @(negedge clk);
        chk("busy_start done count", 512'(done_cnt - dc), 512'(1));

        // ---- reset in the middle of a divide ----
        ma = '0; mb = '0; ma[0][0] = 7; ma[0][1] = 9; mb[0][0] = 0; mb[0][1] = 2;
        @(negedge clk);
        op = 3'd3; rows_a = 1; cols_a = 2; rows_b = 1; cols_b = 2; a = ma; b = mb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (44) @(negedge clk);
        chk("mid_div div_zero sticky", 512'(div_zero), 512'(1));
        chk("mid_div busy", 512'(busy), 512'(1));
        rst = 1'b1;
        @(negedge clk);
        dc = done_cnt;
        chk("rst_div busy", 512'(busy), 512'(0));
        chk("rst_div result", result, 512'(0));
        chk("rst_div div_zero", 512'(div_zero), 512'(0));
        chk("rst_div done", 512'(done), 512'(0));
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("rst_div no done", 512'(done_cnt - dc), 512'(0));
        run_vec(mkv("after_rst", 3'd4, 1, 2, 1, 2, ma, mb), 0);

        chk("scoreboard empty", 512'(sb.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
